// File: rtl/femto8_fetch_decode.sv
`timescale 1ns/1ps
// femto8 fetch/length-decode front end: streams one ROM byte per cycle and
// regroups the bytes into 1-3 byte instructions for the execute stage.
//
// Handshake: an instruction transfers on a clock edge where instr_valid=1 and
// instr_ready=1. While instr_valid=1 and instr_ready=0, every instr_* output
// holds and fetching pauses. redirect beats both accept and completion.
module femto8_fetch_decode #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_re,
  input  logic [7:0]        rom_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [7:0]        opcode,
  output logic [7:0]        opnd_a,
  output logic [7:0]        opnd_b,
  output logic [1:0]        instr_len,
  output logic [2:0]        instr_cls,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {S_OP = 2'd0, S_B1 = 2'd1, S_B2 = 2'd2} state_t;

  // Class: 0 ALU-reg, 1 cond-skip (6x), 2 cond-set (7x), 3 immediate, 4 shift/misc.
  function automatic logic [2:0] dec_cls(input logic [7:0] op);
    logic [2:0] c;
    if (op[7:4] == 4'h6)        c = 3'd1;
    else if (op[7:4] == 4'h7)   c = 3'd2;
    else if (op[7:5] == 3'b111) c = (op[3:2] == 2'b11) ? 3'd4 : 3'd3;
    else                        c = 3'd0;
    return c;
  endfunction

  // Instruction length; a field value of 3 selects a zero-page operand byte.
  function automatic logic [1:0] dec_len(input logic [7:0] op);
    logic [1:0] l;
    case (dec_cls(op))
      3'd0:    l = 2'd1 + {1'b0, &op[3:2]} + {1'b0, &op[1:0]};
      3'd3:    l = 2'd2 + {1'b0, &op[1:0]};
      3'd4:    l = op[4] ? 2'd2 : (op[1] ? 2'd1 : 2'd3);
      default: l = 2'd1;
    endcase
    return l;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              data_vld_q;
  logic [7:0]        op_q, a_q;
  logic [ADDR_W-1:0] pc_q;
  logic [1:0]        len_q;
  logic              instr_valid_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic [7:0]        opcode_q, opnd_a_q, opnd_b_q;
  logic [1:0]        instr_len_q;
  logic [2:0]        instr_cls_q;

  logic              stall, fetch, consume, complete;
  logic [1:0]        len_now;
  logic [ADDR_W-1:0] f_pc;
  logic [7:0]        f_op, f_a, f_b;
  logic [1:0]        f_len;

  assign stall   = instr_valid_q & ~instr_ready;
  assign fetch   = ~stall & ~redirect;
  assign consume = data_vld_q & ~stall;
  assign len_now = dec_len(rom_data);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_OP;
    else       state_q <= state_d;
  end

  // FSM next state: advance one byte position per consumed byte.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = S_OP;
    end else if (consume) begin
      case (state_q)
        S_OP:    state_d = (len_now == 2'd1) ? S_OP : S_B1;
        S_B1:    state_d = (len_q == 2'd2) ? S_OP : S_B2;
        default: state_d = S_OP;
      endcase
    end
  end

  // FSM outputs: completion strobe and the fully assembled instruction fields.
  always_comb begin
    complete = 1'b0;
    f_pc     = pc_q;
    f_op     = op_q;
    f_a      = 8'h00;
    f_b      = 8'h00;
    f_len    = len_q;
    case (state_q)
      S_OP: begin
        complete = consume & ~redirect & (len_now == 2'd1);
        f_pc     = rom_addr_q - ADDR_W'(1);
        f_op     = rom_data;
        f_len    = len_now;
      end
      S_B1: begin
        complete = consume & ~redirect & (len_q == 2'd2);
        f_a      = rom_data;
      end
      default: begin
        complete = consume & ~redirect;
        f_a      = a_q;
        f_b      = rom_data;
        f_len    = 2'd3;
      end
    endcase
  end

  // Fetch pointer and byte-valid flag; rom_data always belongs to rom_addr-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_addr_q <= '0;
      data_vld_q <= 1'b0;
    end else if (redirect) begin
      rom_addr_q <= redirect_pc;
      data_vld_q <= 1'b0;
    end else if (fetch) begin
      rom_addr_q <= rom_addr_q + ADDR_W'(1);
      data_vld_q <= 1'b1;
    end
  end

  // Partial-instruction holding registers (opcode, its PC, length, first operand).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= '0;
      a_q   <= '0;
      pc_q  <= '0;
      len_q <= '0;
    end else if (redirect) begin
      op_q  <= '0;
      a_q   <= '0;
      pc_q  <= '0;
      len_q <= '0;
    end else if (consume && state_q == S_OP) begin
      op_q  <= rom_data;
      pc_q  <= rom_addr_q - ADDR_W'(1);
      len_q <= len_now;
    end else if (consume && state_q == S_B1) begin
      a_q   <= rom_data;
    end
  end

  // Output instruction register: reload on completion, drop on accept or redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_valid_q <= 1'b0;
      instr_pc_q    <= '0;
      opcode_q      <= '0;
      opnd_a_q      <= '0;
      opnd_b_q      <= '0;
      instr_len_q   <= '0;
      instr_cls_q   <= '0;
    end else if (redirect) begin
      instr_valid_q <= 1'b0;
    end else if (complete) begin
      instr_valid_q <= 1'b1;
      instr_pc_q    <= f_pc;
      opcode_q      <= f_op;
      opnd_a_q      <= f_a;
      opnd_b_q      <= f_b;
      instr_len_q   <= f_len;
      instr_cls_q   <= dec_cls(f_op);
    end else if (instr_ready) begin
      instr_valid_q <= 1'b0;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign rom_re      = fetch;
  assign instr_valid = instr_valid_q;
  assign instr_pc    = instr_pc_q;
  assign opcode      = opcode_q;
  assign opnd_a      = opnd_a_q;
  assign opnd_b      = opnd_b_q;
  assign instr_len   = instr_len_q;
  assign instr_cls   = instr_cls_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_femto8_fetch_decode.sv
`timescale 1ns/1ps
// Bench for femto8_fetch_decode: a ROM model feeds the DUT, a reference parser
// walks the ROM image and queues the expected instruction stream, and a
// monitor compares every accepted instruction against that queue.
module tb_femto8_fetch_decode;
  localparam int AW = 10;
  localparam int EW = AW + 8 + 8 + 8 + 2 + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rom_addr;
  logic          rom_re;
  logic [7:0]    rom_data;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [AW-1:0] instr_pc;
  logic [7:0]    opcode, opnd_a, opnd_b;
  logic [1:0]    instr_len;
  logic [2:0]    instr_cls;
  logic [1:0]    dbg_state;

  femto8_fetch_decode #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_re(rom_re),
    .rom_data(rom_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_pc(instr_pc),
    .opcode(opcode), .opnd_a(opnd_a), .opnd_b(opnd_b), .instr_len(instr_len),
    .instr_cls(instr_cls), .dbg_state(dbg_state)
  );

  // ---------------- clock / ROM ----------------
  always #5 clk = ~clk;

  logic [7:0] rom [0:1023];
  always @(posedge clk) if (rom_re) rom_data <= rom[rom_addr];

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  int pop_cnt = 0;
  int pop_base = 0;
  logic [EW-1:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic int ref_cls(input int op);
    if (op >= 'h60 && op <= 'h6F) return 1;
    if (op >= 'h70 && op <= 'h7F) return 2;
    if (op >= 'hE0) return ((op % 16) >= 12) ? 4 : 3;
    return 0;
  endfunction

  function automatic int ref_len(input int op);
    int s, d;
    s = (op / 4) % 4;
    d = op % 4;
    case (ref_cls(op))
      0: return 1 + ((s == 3) ? 1 : 0) + ((d == 3) ? 1 : 0);
      3: return 2 + ((d == 3) ? 1 : 0);
      4: begin
        if (op == 'hEC || op == 'hED) return 3;
        if (op == 'hEE || op == 'hEF) return 1;
        return 2;
      end
      default: return 1;
    endcase
  endfunction

  // Parse the ROM image from 'start' and queue 'count' expected instructions.
  task automatic push_expected(input int start, input int count);
    int pc, op, len, a, b;
    logic [EW-1:0] e;
    pc = start;
    for (int i = 0; i < count; i++) begin
      op  = rom[pc];
      len = ref_len(op);
      a   = (len >= 2) ? rom[(pc + 1) % 1024] : 0;
      b   = (len == 3) ? rom[(pc + 2) % 1024] : 0;
      e   = {AW'(pc), 8'(op), 8'(a), 8'(b), 2'(len), 3'(ref_cls(op))};
      exp_q.push_back(e);
      pc = (pc + len) % 1024;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] act, e;
    if (!reset && !redirect && instr_valid && instr_ready) begin
      act = {instr_pc, opcode, opnd_a, opnd_b, instr_len, instr_cls};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL instr_unexpected: got pc=%h op=%h a=%h b=%h len=%0d cls=%0d, none expected",
                 instr_pc, opcode, opnd_a, opnd_b, instr_len, instr_cls);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          miscompares++;
          $display("FAIL instr: got pc=%h op=%h a=%h b=%h len=%0d cls=%0d, expected pc=%h op=%h a=%h b=%h len=%0d cls=%0d",
                   instr_pc, opcode, opnd_a, opnd_b, instr_len, instr_cls,
                   e[EW-1 -: AW], e[28:21], e[20:13], e[12:5], e[4:3], e[2:0]);
        end
      end
      pop_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom_range(0, 255));
  endtask

  // Redirect to addr, arm the scoreboard, and check the flush edge.
  task automatic start(input int addr, input int npush);
    redirect    = 1'b1;
    redirect_pc = AW'(addr);
    exp_q.delete();
    push_expected(addr, npush);
    pop_base = pop_cnt;
    step();
    check("redirect_valid_clr", 64'(instr_valid), 64'(0));
    check("redirect_addr", 64'(rom_addr), 64'(addr));
    redirect = 1'b0;
  endtask

  task automatic wait_pops(input int n, input bit rnd);
    int cyc;
    cyc = 0;
    while (pop_cnt < pop_base + n && cyc < n * 12 + 40) begin
      instr_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
      cyc++;
    end
    instr_ready = 1'b1;
    if (pop_cnt < pop_base + n) begin
      vectors++;
      miscompares++;
      $display("FAIL pop_timeout: got %0d instructions expected %0d", pop_cnt - pop_base, n);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
    fill_random();
    #1;
    check("reset_outputs",
          64'({instr_valid, instr_pc, opcode, opnd_a, opnd_b, instr_len, instr_cls, rom_addr}), 64'(0));
    check("reset_rom_re", 64'(rom_re), 64'(1));

    // Basic stream with latency checks
    rom[0] = 8'h00; rom[1] = 8'h01; rom[2] = 8'h0F; rom[3] = 8'h11; rom[4] = 8'h22; rom[5] = 8'h60;
    push_expected(0, 16);
    pop_base = 0;
    step(); step();
    reset = 1'b0;
    step();
    check("latency_edge1", 64'(instr_valid), 64'(0));
    step();
    check("latency_edge2", 64'({instr_valid, instr_pc}), 64'({1'b1, 10'h000}));
    step();
    check("back_to_back", 64'({instr_valid, instr_pc}), 64'({1'b1, 10'h001}));
    wait_pops(6, 1'b0);

    // Immediate / shift / misc classes
    rom[10'h040] = 8'hE3; rom[10'h041] = 8'h05; rom[10'h042] = 8'h40; rom[10'h043] = 8'hFC;
    rom[10'h044] = 8'h80; rom[10'h045] = 8'hEE; rom[10'h046] = 8'h7E;
    start('h040, 14);
    wait_pops(6, 1'b1);

    // Back-pressure holds the instruction and freezes fetch
    rom[10'h080] = 8'h0F; rom[10'h081] = 8'h11; rom[10'h082] = 8'h22; rom[10'h083] = 8'h01;
    start('h080, 14);
    instr_ready = 1'b0;
    cyc = 0;
    while (!instr_valid && cyc < 10) begin step(); cyc++; end
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_hold",
            64'({instr_valid, instr_pc, opcode, opnd_a, opnd_b, instr_len, instr_cls}),
            64'({1'b1, 10'h080, 8'h0F, 8'h11, 8'h22, 2'd3, 3'd0}));
      check("stall_rom_re", 64'(rom_re), 64'(0));
      check("stall_addr", 64'(rom_addr), 64'(10'h084));
    end
    wait_pops(6, 1'b0);

    // Redirect drops a partially fetched instruction
    rom[10'h100] = 8'h0F; rom[10'h101] = 8'h11; rom[10'h102] = 8'h22;
    rom[10'h3F0] = 8'h01;
    start('h100, 4);
    step(); step();
    check("partial_not_valid", 64'(instr_valid), 64'(0));
    start('h3F0, 14);
    step();
    check("redir_latency_edge2", 64'(instr_valid), 64'(0));
    step();
    check("redir_first_instr", 64'({instr_valid, instr_pc, opcode}), 64'({1'b1, 10'h3F0, 8'h01}));
    wait_pops(6, 1'b1);

    // Instruction straddling the top of the address space
    fill_random();
    rom[10'h3FE] = 8'h1F; rom[10'h3FF] = 8'hAA; rom[10'h000] = 8'hBB;
    start('h3FE, 14);
    wait_pops(6, 1'b1);

    // Asynchronous reset in the middle of an instruction
    rom[10'h200] = 8'h0F; rom[10'h201] = 8'h11; rom[10'h202] = 8'h22;
    start('h200, 4);
    step(); step();
    reset = 1'b1;
    #1;
    check("reset_async_outputs",
          64'({instr_valid, instr_pc, opcode, opnd_a, opnd_b, instr_len, instr_cls, rom_addr}), 64'(0));
    check("reset_async_rom_re", 64'(rom_re), 64'(1));
    step(); step();
    check("reset_hold_outputs",
          64'({instr_valid, instr_pc, opcode, opnd_a, opnd_b, instr_len, instr_cls, rom_addr}), 64'(0));
    exp_q.delete();
    fill_random();
    rom[0] = 8'hE3; rom[1] = 8'h05; rom[2] = 8'h40; rom[3] = 8'hFC; rom[4] = 8'h80; rom[5] = 8'h00;
    push_expected(0, 14);
    pop_base = pop_cnt;
    reset = 1'b0;
    wait_pops(6, 1'b1);

    // Random images, random start points, random back-pressure
    for (int r = 0; r < 4; r++) begin
      fill_random();
      start($urandom_range(0, 1023), 48);
      wait_pops(40, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
